md_unit: RTL and testbench
==========================

# md_unit

Multi-cycle multiply/divide responder for the five-stage MIPS pipeline. It accepts one-cycle start requests from the EX stage, runs a fixed-latency multiply, multiply-accumulate or divide, and holds the architectural HI/LO registers. It reports `busy` so the hazard controller can stall HI/LO consumers and new MD requests. It also serves `mthi`/`mtlo` writes and `mfhi`/`mflo` reads.

## Interface
Parameters:
- `MULT_CYCLES`, 5: busy cycles for MULT/MULTU/MADD/MSUB (legal 1..15).
- `DIV_CYCLES`, 10: busy cycles for DIV/DIVU (legal 1..15).

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on rising `clk` only.
- `start`  in  1  request strobe from EX; one cycle per request.
- `md_op`  in  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MSUB, 6 MTHI, 7 MTLO.
- `a`  in  32  operand rs (dividend / multiplicand / MTHI-MTLO source).
- `b`  in  32  operand rt (divisor / multiplier).
- `busy`  out  1  operation in flight; HI/LO not yet final.
- `done`  out  1  one-cycle pulse: HI/LO were just updated by a timed operation.
- `hi`  out  32  architectural HI.
- `lo`  out  32  architectural LO.

## Operation
- Two states:
  - IDLE: `busy`=0.
  - RUN: `busy`=1; a 4-bit down-counter is loaded with the op latency.
- Accept rule: a request is accepted when `start`=1 and `busy`=0. If `start`=1 while `busy`=1, the request is ignored and no state changes. The hazard controller must prevent this; the block does not queue it.
- Timed ops (0–5):
  - On accept, latch `a`, `b` and `md_op`, load the counter, and enter RUN.
  - Each cycle in RUN, decrement the counter.
  - When the counter reaches 1, the next edge writes HI/LO, returns to IDLE and pulses `done`.
- MTHI/MTLO (6, 7): on accept, `hi`←`a` (or `lo`←`a`) at the same edge. No RUN state, no `done`.
- Arithmetic (all results computed on the latched operands):
  - MULT: {HI,LO} = signed 64-bit product.
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - MADD: {HI,LO} = {HI,LO} + signed a*b, mod 2^64. HI/LO are sampled at completion, not at accept.
  - MSUB: {HI,LO} = {HI,LO} − signed a*b, mod 2^64.
  - DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: LO = unsigned quotient; HI = unsigned remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- Divide by zero: runs the full `DIV_CYCLES` with `busy` high, pulses `done`, and leaves HI/LO unchanged.
- `hi`/`lo` are plain register outputs. During RUN they show the old values; the pipeline must not read them while `busy`=1.

## Timing
- Reset (`reset`=0 at an edge) sets:
  - state IDLE, counter 0;
  - `busy`=0, `done`=0, `hi`=0, `lo`=0.
- Reset overrides `start`. Reset during RUN aborts the operation; no `done`, HI/LO go to 0.
- Timed op accepted at edge T:
  - `busy`=1 after edge T through edge T+N, where N is the op latency;
  - HI/LO are updated at edge T+N;
  - `busy`=0 and `done`=1 for the cycle after edge T+N.
- Back-to-back requests: a new `start` presented in the cycle after edge T+N, while `done`=1 and `busy`=0, is accepted. Its MADD/MSUB sees the just-written HI/LO.
- MTHI/MTLO at edge T: new value visible after T; `busy` stays 0.
- `done` never overlaps `busy`=1.
- `md_op` and the operands are ignored whenever `start`=0.

## Test plan
- MULT a=0xFFFFFFFD (−3), b=5 -> `busy` high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1, `done` for one cycle.
- DIV a=0xFFFFFFF9 (−7), b=2 -> 10 busy cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with the same operands -> LO=0x7FFFFFFC, HI=1.
- MTHI a=0x12345678, then MTLO a=1, then MADD a=2, b=3 -> HI=0x12345678, LO=7 after 5 busy cycles. MSUB a=2, b=4 -> LO=0xFFFFFFFF, HI=0x12345677.
- DIV a=10, b=0 with HI=0xA, LO=0xB preloaded -> 10 busy cycles, `done` pulses, HI=0xA, LO=0xB unchanged. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MULTU 0xFFFFFFFF×0xFFFFFFFF accepted; `start` with MTLO a=0x55 on busy cycle 2 -> ignored. Final HI=0xFFFFFFFE, LO=0x00000001.
- DIV accepted, `reset`=0 on busy cycle 4 -> next cycle `busy`=0, `done`=0, HI=LO=0. No `done` pulse afterwards.

Source files
------------

// File: rtl/md_unit.sv
// md_unit
// Multi-cycle multiply/divide unit for the five-stage MIPS pipeline. It
// accepts one-cycle start requests from EX and runs a fixed-latency
// MULT/MULTU/MADD/MSUB/DIV/DIVU. It owns the architectural HI/LO registers
// and serves MTHI/MTLO writes directly.
//
// Ports:
//   clk    - single clock, all state changes on its rising edge
//   reset  - synchronous active-low reset
//   start  - one-cycle request strobe from EX
//   md_op  - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MSUB, 6 MTHI, 7 MTLO
//   a, b   - operands rs and rt
//   busy   - operation in flight, HI/LO not yet final
//   done   - one-cycle pulse after a timed op has written HI/LO
//   hi, lo - architectural HI and LO registers

module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MADD  = 3'd4;
   localparam logic [2:0] OP_MSUB  = 3'd5;
   localparam logic [2:0] OP_MTHI  = 3'd6;
   localparam logic [2:0] OP_MTLO  = 3'd7;

   localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

   state_t      state;
   logic [3:0]  cnt;
   logic [2:0]  op_q;
   logic [31:0] a_q;
   logic [31:0] b_q;

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] div_s_den;
   logic [31:0] div_u_den;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] q_u;
   logic [31:0] r_u;
   logic        div_zero;
   logic [31:0] res_hi;
   logic [31:0] res_lo;

   // Result datapath, evaluated on the latched operands and on the current
   // HI/LO so that MADD/MSUB accumulate onto the values present at completion.
   // The signed product is the low 64 bits of the product of the sign-extended
   // operands. Signed division works on magnitudes and restores signs after,
   // which gives truncation toward zero and makes 0x80000000 / -1 wrap to
   // 0x80000000 with remainder 0. A zero divisor is replaced by 1 purely to
   // keep the divider defined; its result is discarded and HI/LO are kept.
   always_comb begin
      prod_s    = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
      prod_u    = {32'd0, a_q} * {32'd0, b_q};
      div_zero  = (b_q == 32'd0);
      a_mag     = a_q[31] ? (32'd0 - a_q) : a_q;
      b_mag     = b_q[31] ? (32'd0 - b_q) : b_q;
      div_s_den = div_zero ? 32'd1 : b_mag;
      div_u_den = div_zero ? 32'd1 : b_q;
      q_mag     = a_mag / div_s_den;
      r_mag     = a_mag % div_s_den;
      q_u       = a_q / div_u_den;
      r_u       = a_q % div_u_den;
      res_hi    = hi;
      res_lo    = lo;
      case (op_q)
         OP_MULT:  {res_hi, res_lo} = prod_s;
         OP_MULTU: {res_hi, res_lo} = prod_u;
         OP_MADD:  {res_hi, res_lo} = {hi, lo} + prod_s;
         OP_MSUB:  {res_hi, res_lo} = {hi, lo} - prod_s;
         OP_DIV: begin
            if (!div_zero) begin
               res_lo = (a_q[31] ^ b_q[31]) ? (32'd0 - q_mag) : q_mag;
               res_hi = a_q[31] ? (32'd0 - r_mag) : r_mag;
            end
         end
         OP_DIVU: begin
            if (!div_zero) begin
               res_lo = q_u;
               res_hi = r_u;
            end
         end
         default: begin
            res_hi = hi;
            res_lo = lo;
         end
      endcase
   end

   // Control FSM. Requests are only looked at in IDLE, so a start while busy
   // is dropped without side effects. MTHI/MTLO complete at the accepting
   // edge; timed ops load the counter and finish on the edge where it is 1.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= IDLE;
         cnt   <= 4'd0;
         op_q  <= 3'd0;
         a_q   <= 32'd0;
         b_q   <= 32'd0;
         busy  <= 1'b0;
         done  <= 1'b0;
         hi    <= 32'd0;
         lo    <= 32'd0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (md_op == OP_MTHI) begin
                     hi <= a;
                  end else if (md_op == OP_MTLO) begin
                     lo <= a;
                  end else begin
                     op_q  <= md_op;
                     a_q   <= a;
                     b_q   <= b;
                     cnt   <= ((md_op == OP_DIV) || (md_op == OP_DIVU)) ? DIV_LAT : MULT_LAT;
                     state <= RUN;
                     busy  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (cnt == 4'd1) begin
                  hi    <= res_hi;
                  lo    <= res_lo;
                  cnt   <= 4'd0;
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit
// Directed bench for md_unit. Each timed request pushes its hand-computed
// HI/LO and busy length onto a queue; a monitor on the falling edge pops and
// compares whenever done pulses. MTHI/MTLO and reset behaviour are checked
// directly by the stimulus thread.

module tb_md_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   typedef struct {
      int          id;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycles;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   int   busy_cnt = 0;

   md_unit #(
      .MULT_CYCLES(5),
      .DIV_CYCLES(10)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .md_op(md_op),
      .a(a),
      .b(b),
      .busy(busy),
      .done(done),
      .hi(hi),
      .lo(lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison, one FAIL line if it disagrees.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   // Present one request for exactly one rising edge. Called at posedge+1.
   task automatic applyStimulus(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb);
      start = 1'b1;
      md_op = op;
      a     = va;
      b     = vb;
      @(posedge clk);
      #1;
      start = 1'b0;
      md_op = 3'd0;
      a     = 32'hDEAD_BEEF;
      b     = 32'hCAFE_F00D;
   endtask

   task automatic pushExpect(input int id, input logic [31:0] eh, input logic [31:0] el, input int cyc);
      exp_t e;
      e.id = id;
      e.hi = eh;
      e.lo = el;
      e.cycles = cyc;
      sb.push_back(e);
   endtask

   // Wait, with a bound, until busy drops.
   task automatic waitIdle(input string name);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (!busy) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      total++;
      if (!ok) begin
         bad++;
         $display("[TB] FAIL %s timeout: busy still %0d after 40 cycles, required 0", name, busy);
      end
   endtask

   // Scoreboard monitor: counts busy cycles and checks every done pulse.
   always @(negedge clk) begin
      if (busy === 1'b1 && done === 1'b1) begin
         total++;
         bad++;
         $display("[TB] FAIL done_busy_overlap: done=1 busy=1, required busy=0");
      end
      if (busy === 1'b1) begin
         busy_cnt++;
      end else if (done === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_done: done=1 with no pending op, required done=0");
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput($sformatf("op%0d_hi", e.id), hi, e.hi);
            checkOutput($sformatf("op%0d_lo", e.id), lo, e.lo);
            checkOutput($sformatf("op%0d_busy_cycles", e.id), 32'(busy_cnt), 32'(e.cycles));
         end
         busy_cnt = 0;
      end else begin
         busy_cnt = 0;
      end
   end

   initial begin
      reset = 1'b0;
      start = 1'b0;
      md_op = 3'd0;
      a     = 32'd0;
      b     = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_busy", {31'd0, busy}, 32'd0);
      checkOutput("reset_done", {31'd0, done}, 32'd0);
      checkOutput("reset_hi", hi, 32'd0);
      checkOutput("reset_lo", lo, 32'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] MULT -3 * 5");
      pushExpect(1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5);
      applyStimulus(3'd0, 32'hFFFF_FFFD, 32'd5);
      waitIdle("mult");

      $display("[TB] DIV / DIVU back to back");
      pushExpect(2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
      applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd2);
      waitIdle("div");
      pushExpect(3, 32'h0000_0001, 32'h7FFF_FFFC, 10);
      applyStimulus(3'd3, 32'hFFFF_FFF9, 32'd2);
      waitIdle("divu");

      $display("[TB] MTHI / MTLO / MADD / MSUB");
      applyStimulus(3'd6, 32'h1234_5678, 32'd0);
      checkOutput("mthi_hi", hi, 32'h1234_5678);
      checkOutput("mthi_busy", {31'd0, busy}, 32'd0);
      applyStimulus(3'd7, 32'h0000_0001, 32'd0);
      checkOutput("mtlo_lo", lo, 32'h0000_0001);
      checkOutput("mtlo_hi_kept", hi, 32'h1234_5678);
      pushExpect(4, 32'h1234_5678, 32'h0000_0007, 5);
      applyStimulus(3'd4, 32'd2, 32'd3);
      waitIdle("madd");
      pushExpect(5, 32'h1234_5677, 32'hFFFF_FFFF, 5);
      applyStimulus(3'd5, 32'd2, 32'd4);
      waitIdle("msub");

      $display("[TB] divide by zero and overflow divide");
      applyStimulus(3'd6, 32'h0000_000A, 32'd0);
      applyStimulus(3'd7, 32'h0000_000B, 32'd0);
      pushExpect(6, 32'h0000_000A, 32'h0000_000B, 10);
      applyStimulus(3'd2, 32'd10, 32'd0);
      waitIdle("div0");
      pushExpect(7, 32'h0000_0000, 32'h8000_0000, 10);
      applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      waitIdle("divovf");

      $display("[TB] MULTU with ignored MTLO while busy");
      pushExpect(8, 32'hFFFF_FFFE, 32'h0000_0001, 5);
      applyStimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      applyStimulus(3'd7, 32'h0000_0055, 32'd0);
      checkOutput("ignored_mtlo_lo", lo, 32'h8000_0000);
      waitIdle("multu");

      $display("[TB] reset aborts DIV");
      applyStimulus(3'd2, 32'd100, 32'd7);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      checkOutput("abort_busy", {31'd0, busy}, 32'd0);
      checkOutput("abort_done", {31'd0, done}, 32'd0);
      checkOutput("abort_hi", hi, 32'd0);
      checkOutput("abort_lo", lo, 32'd0);
      repeat (15) @(posedge clk);
      #1;
      checkOutput("abort_hi_later", hi, 32'd0);
      checkOutput("pending_ops", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
